// File: rtl/add_round_key_stage.sv
// Purpose: registered AddRoundKey stage after mix_columns; XORs the round key into the raw or mixed state and tags the beat with its round.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; a full-rate stream sees no bubbles.
// Backpressure: 2-entry buffer (main + skid); in_ready is a flop output, low only while the skid entry is occupied.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   flush                 synchronous clear of buffer and round counter (output data registers keep their value)
//   in_valid / in_ready   upstream handshake; raw_state, mixed_state_array, round_key sampled on accept
//   out_valid / out_ready downstream handshake; out_state, out_round, out_last describe the oldest buffered beat
module add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   raw_state,
    input  logic [127:0]   mixed_state_array,
    input  logic [127:0]   round_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_state,
    output logic [RW-1:0]  out_round,
    output logic           out_last
);

    localparam logic [RW-1:0] NR_W = RW'(NR);

    logic [RW-1:0] round_cnt;

    // Skid entry: holds the beat accepted while the main register was stalled.
    logic          skid_vld;
    logic [127:0]  skid_state;
    logic [RW-1:0] skid_round;
    logic          skid_last;

    logic          acc;
    logic          pop;
    logic          use_raw;
    logic [127:0]  new_state;
    logic          new_last;

    // Round 0 (initial key add) and round NR (no MixColumns) take the unmixed state.
    always_comb begin
        use_raw   = (round_cnt == '0) || (round_cnt == NR_W);
        new_state = (use_raw ? raw_state : mixed_state_array) ^ round_key;
        new_last  = (round_cnt == NR_W);
    end

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_vld;
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Round counter: advances once per accepted beat and wraps NR -> 0 so the next block starts at round 0.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            round_cnt <= '0;
        end else if (acc) begin
            round_cnt <= (round_cnt == NR_W) ? '0 : round_cnt + RW'(1);
        end
    end

    // Main (output) register plus skid register.
    // When the buffer drains, out_state/out_round/out_last keep their last value; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_round  <= '0;
            out_last   <= 1'b0;
            skid_vld   <= 1'b0;
            skid_state <= '0;
            skid_round <= '0;
            skid_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                // Skid advances into main; no accept is possible here since in_ready is low.
                out_state <= skid_state;
                out_round <= skid_round;
                out_last  <= skid_last;
                skid_vld  <= 1'b0;
            end else if (acc) begin
                // Pop and accept on the same edge: new beat replaces the popped one, no bubble.
                out_state <= new_state;
                out_round <= round_cnt;
                out_last  <= new_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!out_valid) begin
            if (acc) begin
                out_valid <= 1'b1;
                out_state <= new_state;
                out_round <= round_cnt;
                out_last  <= new_last;
            end
        end else if (acc) begin
            // Main is stalled: park the beat in skid; in_ready falls on the next cycle.
            skid_vld   <= 1'b1;
            skid_state <= new_state;
            skid_round <= round_cnt;
            skid_last  <= new_last;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Purpose: directed + randomized bench for add_round_key_stage against a queue-based reference model.
// Latency: model expects results one edge after acceptance.
// Backpressure: model treats the stage as a 2-deep FIFO that accepts while fewer than 2 beats are held.
module tb_add_round_key_stage;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  raw_state;
    logic [127:0]  mixed_state_array;
    logic [127:0]  round_key;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_state;
    logic [RW-1:0] out_round;
    logic          out_last;

    add_round_key_stage #(.NR(NR), .RW(RW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .raw_state         (raw_state),
        .mixed_state_array (mixed_state_array),
        .round_key         (round_key),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_state         (out_state),
        .out_round         (out_round),
        .out_last          (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        int           rnd;
        bit           last;
    } beat_t;

    beat_t        q[$];
    int           rc;
    logic [127:0] shown_st;
    int           shown_rnd;
    bit           shown_last;

    int n_assert;
    int n_fail;
    int n_acc_obs;

    logic [127:0] held_st;
    logic [127:0] saved_raw;
    logic [127:0] saved_key;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        raw_state         = rand128();
        mixed_state_array = rand128();
        round_key         = rand128();
    endtask

    // One clock: decide accept/pop from the model, advance it after the edge, then compare.
    task automatic cycle();
        bit    m_acc;
        bit    m_pop;
        beat_t b;
        m_acc  = in_valid && (q.size() < 2);
        m_pop  = (q.size() > 0) && out_ready;
        if (!rst && !flush && in_valid && in_ready) n_acc_obs++;
        b.st   = (((rc == 0) || (rc == NR)) ? raw_state : mixed_state_array) ^ round_key;
        b.rnd  = rc;
        b.last = (rc == NR);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            rc         = 0;
            shown_st   = '0;
            shown_rnd  = 0;
            shown_last = 1'b0;
        end else if (flush) begin
            q.delete();
            rc = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(b);
                rc = (rc == NR) ? 0 : rc + 1;
            end
        end
        if (q.size() > 0) begin
            shown_st   = q[0].st;
            shown_rnd  = q[0].rnd;
            shown_last = q[0].last;
        end
        chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
        chk("in_ready",  {127'd0, in_ready},  {127'd0, q.size() < 2});
        chk("out_state", out_state, shown_st);
        chk("out_round", {124'd0, out_round}, 128'(shown_rnd));
        chk("out_last",  {127'd0, out_last},  {127'd0, shown_last});
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        n_acc_obs = 0;
        rc        = 0;
        shown_st  = '0;
        shown_rnd = 0;
        shown_last = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        raw_state = '0;
        mixed_state_array = '0;
        round_key = '0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_ready", {127'd0, in_ready}, 128'd1);
        chk("reset_state", out_state, 128'd0);
        chk("reset_round", {124'd0, out_round}, 128'd0);
        chk("reset_last",  {127'd0, out_last}, 128'd0);

        // Round 0, FIPS-197 vector
        in_valid          = 1'b1;
        raw_state         = 128'h3243f6a8885a308d313198a2e0370734;
        round_key         = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        mixed_state_array = rand128();
        cycle();
        chk("r0_valid", {127'd0, out_valid}, 128'd1);
        chk("r0_state", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("r0_round", {124'd0, out_round}, 128'd0);
        chk("r0_last",  {127'd0, out_last}, 128'd0);

        // Round 1, mixed state selected
        raw_state         = rand128();
        mixed_state_array = 128'h046681e5e0cb199a48f8d37a2806264c;
        round_key         = 128'ha0fafe1788542cb123a339392a6c7605;
        cycle();
        chk("r1_state", out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("r1_round", {124'd0, out_round}, 128'd1);

        // Rounds 2..9 random
        for (int r = 2; r < NR; r++) begin
            rand_data();
            cycle();
        end

        // Final round, raw state selected
        raw_state         = 128'he9317db5cb322c723d2e895faf090794;
        round_key         = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        mixed_state_array = rand128();
        cycle();
        chk("rN_state", out_state, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("rN_round", {124'd0, out_round}, 128'd10);
        chk("rN_last",  {127'd0, out_last}, 128'd1);

        // Wrap to round 0
        rand_data();
        cycle();
        chk("wrap_round", {124'd0, out_round}, 128'd0);
        chk("wrap_last",  {127'd0, out_last}, 128'd0);
        in_valid = 1'b0;
        cycle();

        // Backpressure: only two beats fit, output held stable
        n_acc_obs = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        held_st   = '0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle();
            if (i == 0) held_st = out_state;
            else chk("bp_stable", out_state, held_st);
        end
        chk("bp_accepts", 128'(n_acc_obs), 128'd2);
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_drained", {127'd0, out_valid}, 128'd0);
        chk("bp_ready_back", {127'd0, in_ready}, 128'd1);

        // Streaming from round 0: one result per cycle
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            rand_data();
            cycle();
            chk("stream_valid", {127'd0, out_valid}, 128'd1);
            chk("stream_round", {124'd0, out_round}, 128'(i % (NR + 1)));
        end
        in_valid = 1'b0;
        cycle();

        // Flush mid-block with skid full
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle();
        end
        out_ready = 1'b0;
        rand_data();
        cycle();
        chk("pre_flush_ready", {127'd0, in_ready}, 128'd0);
        flush = 1'b1;
        rand_data();
        cycle();
        flush = 1'b0;
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        rand_data();
        saved_raw = raw_state;
        saved_key = round_key;
        cycle();
        chk("flush_next_round", {124'd0, out_round}, 128'd0);
        chk("flush_next_state", out_state, saved_raw ^ saved_key);

        // Reset mid-block with skid full
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
        end
        out_ready = 1'b0;
        rand_data();
        cycle();
        chk("pre_rst_ready", {127'd0, in_ready}, 128'd0);
        rst = 1'b1;
        rand_data();
        cycle();
        rst = 1'b0;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_state", out_state, 128'd0);
        chk("rst_round", {124'd0, out_round}, 128'd0);
        out_ready = 1'b1;
        rand_data();
        saved_raw = raw_state;
        saved_key = round_key;
        cycle();
        chk("rst_next_round", {124'd0, out_round}, 128'd0);
        chk("rst_next_state", out_state, saved_raw ^ saved_key);
        in_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage placed directly downstream of mix_columns in the iterative AES datapath.
- Per accepted beat, it XORs the current round key into either the mixed state (middle rounds) or the unmixed state (round 0 and the final round).
- It tracks the round number internally and flags the last round.
- It decouples the combinational round logic from the next stage with a valid/ready handshake and a 2-entry skid buffer.

Parameters:
- NR, 10, number of rounds; 10 for AES-128, 14 for AES-256.
- RW, 4, round counter width; must satisfy 2^RW > NR.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear: empties the buffer and returns the round counter to 0; does not touch reset-only state.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- raw_state  in  128  unmixed state (plaintext in round 0, ShiftRows output in round NR).
- mixed_state_array  in  128  mix_columns output, used in rounds 1..NR-1.
- round_key  in  128  round key for the current round; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_state  out  128  selected state XOR round_key.
- out_round  out  RW  round index of the output beat.
- out_last  out  1  out_round == NR.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - out_valid=0, in_ready=1, out_state=0, out_round=0, out_last=0;
  - internal round_cnt=0, both buffer entries empty.
- Accept rule: a beat is accepted on an edge where in_valid && in_ready.
  - Operand = raw_state if round_cnt==0 or round_cnt==NR, else mixed_state_array.
  - Result = operand ^ round_key, tagged with round_cnt.
- Round counter:
  - Increments by 1 per accepted beat.
  - Wraps from NR to 0, so the next block starts automatically.
  - Never changes without an accept.
- Latency: 1 cycle. A beat accepted at edge N is presented with out_valid=1 after edge N when the buffer was empty.
- Buffer: main register plus skid register (2 entries).
  - Output always shows the oldest entry.
  - in_ready is registered: in_ready = !(skid entry occupied).
  - Accept while the main register is held (out_valid && !out_ready) places the beat in skid; in_ready drops the next cycle.
  - Out handshake (out_valid && out_ready) pops the main entry; skid moves to main in the same edge.
  - Simultaneous pop and accept: the new beat enters the slot freed; no bubble, no loss, order preserved.
  - Buffer empty: out_valid=0, out_state/out_round/out_last hold their last value.
- Stability: while out_valid && !out_ready, out_state/out_round/out_last must not change.
- flush (same edge priority below rst, above handshakes):
  - Buffer emptied, out_valid=0, round_cnt=0, in_ready=1 next cycle.
  - A beat presented in the flush cycle is dropped.
- rst mid-block: same effect as flush plus output registers cleared; no partial state survives.
- No combinational path from out_ready to in_ready.

Test Plan:
- Round 0 (FIPS-197): after reset, raw_state=3243f6a8885a308d313198a2e0370734, round_key=2b7e151628aed2a6abf7158809cf4f3c -> next cycle out_valid=1, out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
- Middle round: round_cnt=1, mixed_state_array=046681e5e0cb199a48f8d37a2806264c, round_key=a0fafe1788542cb123a339392a6c7605, raw_state=random -> out_state=a49c7ff2689f352b6b5bea43026a5049, out_round=1.
- Final round: drive 10 beats, 10th with raw_state=e9317db5cb322c723d2e895faf090794, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, mixed=random -> out_state=3925841d02dc09fbdc118597196a0b32, out_round=10, out_last=1. Next accepted beat gets out_round=0.
- Backpressure: out_ready=0 with continuous in_valid -> exactly 2 beats accepted, in_ready=0 from the following cycle, out_state stable. Raise out_ready -> both beats drain in order, in_ready=1 again, no beat duplicated or lost.
- Streaming: in_valid=out_ready=1 for 22 cycles (NR=10) -> one result per cycle, out_round sequence 0..10,0..10, no bubbles.
- Flush/reset mid-block: after 5 accepts, with skid full, assert flush 1 cycle -> out_valid=0, in_ready=1. Next accepted beat is treated as round 0 (raw_state selected, out_round=0). Repeat with rst -> additionally out_state=0.
